fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage for the MIPS core. It holds the PC and drives the instruction-memory address port. It captures the combinationally returned instruction word into a small prefetch FIFO and hands {pc, instruction} pairs to decode over a valid/ready handshake. Branch and jump redirects flush the FIFO and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 4, prefetch FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level/pulse; sampled high in IDLE or HALTED begins fetching
halt  input  1  stop fetching (from CPU, e.g. syscall/break)
address_inst  output  32  word address to instruction memory
instruction  input  32  instruction word returned same cycle for address_inst
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  new fetch target
out_valid  output  1  FIFO head valid
out_ready  input  1  decode accepts head
out_inst  output  32  head instruction
out_pc  output  32  head PC
fill_level  output  $clog2(DEPTH)+1  current FIFO occupancy
misalign_err  output  1  sticky: redirect target not word-aligned

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: pc=RESET_PC, state=IDLE, FIFO empty, out_valid=0, out_inst=0, out_pc=0, fill_level=0, misalign_err=0.
- Reset asserted mid-operation discards all entries immediately. Fetch resumes only after a new start.
- address_inst = pc register, driven continuously in every state.
- FSM states:
  - IDLE -> RUN on start.
  - RUN -> HALTED on halt.
  - HALTED -> RUN on start.
  - halt and start together: halt wins.
- Push (RUN only): if !halt && !redirect_valid && (count<DEPTH || pop), write {pc, instruction} at tail and pc <= pc+4. Otherwise pc holds.
- Pop: out_valid && out_ready. Head advances.
- out_valid = count!=0. out_inst and out_pc come from head storage; they are stable while out_valid && !out_ready.
- Full with simultaneous pop and push: count unchanged, both complete.
- Empty: no pop; out_inst and out_pc hold their last values.
- Redirect (any state) has priority over push and pop:
  - FIFO flushed, count=0 next cycle.
  - pc <= redirect_pc; no push that cycle.
  - A pop asserted in the same cycle counts as accepted by decode, but the FIFO is cleared regardless.
  - State is not changed.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Latency:
  - start sampled at edge N gives state=RUN after edge N.
  - First push at edge N+1.
  - out_valid=1 after edge N+1, with out_pc=RESET_PC.
  - Steady state: one instruction per cycle when out_ready=1.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined: a redirect with redirect_pc[1:0]!=0 sets misalign_err (sticky until reset). pc loads {redirect_pc[31:2],2'b00}.
- Undefined: misalign_err tied 0; pc loads redirect_pc unmodified.

Decomposition:
- fetch_pkg holds:
  - fetch_state_e {IDLE, RUN, HALTED}
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] inst;}
  - PC_STEP=32'd4
- Sub-module fetch_fifo (parameter DEPTH; entry type fetch_entry_t):
  - ports: push, pop, flush, din, dout, count.
  - wr/rd pointers with an extra wrap bit.

Test Plan:
1. Reset, start pulse, out_ready=1, memory words 0..3 = 0x11,0x22,0x33,0x44 -> out_valid rises 2 cycles after start; pairs (0,0x11),(4,0x22),(8,0x33),(C,0x44) appear on consecutive cycles.
2. out_ready=0 after start -> fill_level reaches 4; address_inst holds 0x10; head stays (0,0x11). Then out_ready=1 -> no gaps; next entries PC 0x10,0x14.
3. FIFO full, out_ready=1 each cycle -> fill_level stays 4; one pair popped and one pushed per cycle.
4. Three entries queued, redirect_valid with redirect_pc=0x40 -> next cycle fill_level=0, out_valid=0, address_inst=0x40; following cycle head out_pc=0x40.
5. halt mid-run -> pc freezes and FIFO drains to 0. start -> fetch continues from the frozen pc.
6. rst_n low during RUN with 2 entries -> out_valid=0 and address_inst=RESET_PC asynchronously; no fetch until start. With FETCH_MISALIGN_CHECK_EN defined, redirect_pc=0x42 -> misalign_err=1 and address_inst=0x40.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Prefetch FIFO of {pc, inst} entries; flush clears all entries.
// Revision : 1.0
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_din,
    output fetch_entry_t             o_dout,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : MIPS fetch stage: PC, imem address, prefetch FIFO to decode.
//            Optional FETCH_MISALIGN_CHECK_EN: flag and align redirect targets.
// Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     halt,
    output logic [31:0]              address_inst,
    input  logic [31:0]              instruction,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     misalign_err
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

    fetch_state_e   r_state;
    logic [31:0]    r_pc;
    fetch_entry_t   r_hold;
    fetch_entry_t   w_head;
    fetch_entry_t   w_din;
    logic [CW-1:0]  w_count;
    logic           w_push;
    logic           w_pop;
    logic [31:0]    w_redirect_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_misalign <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            r_misalign <= 1'b1;
    end

    assign misalign_err = r_misalign;
`else
    assign w_redirect_tgt = redirect_pc;
    assign misalign_err   = 1'b0;
`endif

    assign out_valid = (w_count != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = (r_state == RUN) && !halt && !redirect_valid &&
                       ((w_count != C_DEPTH) || w_pop);
    assign w_din     = '{pc: r_pc, inst: instruction};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                IDLE:    if (start && !halt) r_state <= RUN;
                RUN:     if (halt)           r_state <= HALTED;
                HALTED:  if (start && !halt) r_state <= RUN;
                default:                     r_state <= IDLE;
            endcase
            if (redirect_valid)
                r_pc <= w_redirect_tgt;
            else if (w_push)
                r_pc <= r_pc + PC_STEP;
        end
    end

    // Remembers the last presented head so outputs hold while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_hold <= '0;
        else if (out_valid)
            r_hold <= w_head;
    end

    fetch_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_din   (w_din),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    assign address_inst = r_pc;
    assign out_inst     = out_valid ? w_head.inst : r_hold.inst;
    assign out_pc       = out_valid ? w_head.pc   : r_hold.pc;
    assign fill_level   = w_count;

endmodule
`default_nettype wire
